// File: rtl/fir4_chan_sched_pkg.sv
// Shared types and constants for the multi-channel fir4 scheduler.
package fir4_sched_pkg;

    localparam int CHAN_W_MAX = 3;
    localparam int MAX_LAT    = 4;

    localparam logic [1:0] CNT_PRIMED = 2'd3;

    typedef logic [CHAN_W_MAX-1:0] chan_t;

    typedef struct packed {
        logic  valid;
        chan_t chan;
        logic  primed;
    } tag_t;

    // Warm-up counter step: saturates once the history is full.
    function automatic logic [1:0] cnt_inc(input logic [1:0] cnt);
        if (cnt == CNT_PRIMED) begin
            return cnt;
        end else begin
            return cnt + 2'd1;
        end
    endfunction

endpackage

// File: rtl/fir4_chan_sched_if.sv
// Sample, tap and result bundle between the scheduler (slave) and its environment (master).
interface fir4_chan_sched_if #(
    parameter int W   = 16,
    parameter int NCH = 4,
    parameter int CW  = $clog2(NCH)
);
    logic               en;
    logic [NCH-1:0]     in_valid;
    logic [NCH*W-1:0]   in_data;
    logic [NCH-1:0]     in_ready;
    logic [NCH-1:0]     flush;
    logic [W-1:0]       tap_a;
    logic [W-1:0]       tap_b;
    logic [W-1:0]       tap_c;
    logic [W-1:0]       tap_d;
    logic               tap_valid;
    logic [CW-1:0]      tap_chan;
    logic [W+1:0]       sum_in;
    logic               out_valid;
    logic [CW-1:0]      out_chan;
    logic [W+1:0]       out_sum;
    logic               out_primed;

    modport slave (
        input  en, in_valid, in_data, flush, sum_in,
        output in_ready, tap_a, tap_b, tap_c, tap_d, tap_valid, tap_chan,
               out_valid, out_chan, out_sum, out_primed
    );

    modport master (
        output en, in_valid, in_data, flush, sum_in,
        input  in_ready, tap_a, tap_b, tap_c, tap_d, tap_valid, tap_chan,
               out_valid, out_chan, out_sum, out_primed
    );

endinterface

// File: rtl/fir4_chan_sched_rr_arb.sv
// NCH-way round-robin arbiter: one-hot grant searched cyclically from a registered pointer.
module fir4_rr_arb #(
    parameter int NCH = 4,
    parameter int CW  = $clog2(NCH)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic [NCH-1:0] req,
    output logic [NCH-1:0] gnt,
    output logic [CW-1:0]  gnt_idx,
    output logic           gnt_any
);

    logic [CW-1:0] ptr_q;
    logic [CW-1:0] ptr_d;
    logic [CW:0]   idx_s;

    // First requester at or after the pointer; suppressed while in reset.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        idx_s   = '0;
        for (int k = 0; k < NCH; k++) begin
            idx_s = {1'b0, ptr_q} + (CW+1)'(k);
            if (idx_s >= (CW+1)'(NCH)) begin
                idx_s = idx_s - (CW+1)'(NCH);
            end else begin
                idx_s = idx_s;
            end
            if (en && rst_n && !gnt_any && req[idx_s[CW-1:0]]) begin
                gnt_any                = 1'b1;
                gnt[idx_s[CW-1:0]]     = 1'b1;
                gnt_idx                = idx_s[CW-1:0];
            end else begin
                gnt_any = gnt_any;
            end
        end
    end

    // Pointer moves past the winner; holds when nothing is granted.
    always_comb begin
        if (gnt_any) begin
            if (gnt_idx == CW'(NCH-1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + CW'(1);
            end
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fir4_chan_sched.sv
// Channel scheduler for a shared 4-tap FIR adder: arbitration, per-channel history,
// tap issue and channel-tag tracking across the external datapath latency.
module fir4_chan_sched
    import fir4_sched_pkg::*;
#(
    parameter int w   = 16,
    parameter int NCH = 4,
    parameter int LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    fir4_chan_sched_if.slave   bus
);

    localparam int CW    = $clog2(NCH);
    localparam int DEPTH = (LAT > MAX_LAT) ? MAX_LAT : ((LAT < 1) ? 1 : LAT);

    logic [NCH-1:0]        gnt_s;
    logic [CW-1:0]         gidx_s;
    logic                  gany_s;
    logic signed [w-1:0]   x_s;

    logic signed [w-1:0]   hist_q [NCH][3];
    logic signed [w-1:0]   hist_d [NCH][3];
    logic [1:0]            cnt_q  [NCH];
    logic [1:0]            cnt_d  [NCH];

    logic signed [w-1:0]   tap_a_q, tap_a_d, tap_b_q, tap_b_d;
    logic signed [w-1:0]   tap_c_q, tap_c_d, tap_d_q, tap_d_d;
    logic                  tap_valid_q, tap_valid_d;
    logic [CW-1:0]         tap_chan_q, tap_chan_d;
    logic                  tap_primed_q, tap_primed_d;

    tag_t                  tag_q [DEPTH];
    tag_t                  tag_d [DEPTH];
    tag_t                  tail_s;
    logic                  tail_ok_s;

    logic                  out_valid_q, out_valid_d;
    logic [CW-1:0]         out_chan_q, out_chan_d;
    logic [w+1:0]          out_sum_q, out_sum_d;
    logic                  out_primed_q, out_primed_d;

    fir4_rr_arb #(.NCH(NCH), .CW(CW)) u_arb (
        .clk     (clk),
        .rst_n   (reset),
        .en      (bus.en),
        .req     (bus.in_valid),
        .gnt     (gnt_s),
        .gnt_idx (gidx_s),
        .gnt_any (gany_s)
    );

    assign bus.in_ready = gnt_s;

    // Sample of the granted channel.
    always_comb begin
        x_s = '0;
        for (int i = 0; i < NCH; i++) begin
            if (gidx_s == CW'(i)) begin
                x_s = bus.in_data[i*w +: w];
            end else begin
                x_s = x_s;
            end
        end
    end

    // History/count update and tap vector; flushes land before the accept so a
    // same-cycle flush+accept issues (x,0,0,0) and restarts the warm-up.
    always_comb begin
        hist_d       = hist_q;
        cnt_d        = cnt_q;
        tap_a_d      = tap_a_q;
        tap_b_d      = tap_b_q;
        tap_c_d      = tap_c_q;
        tap_d_d      = tap_d_q;
        tap_valid_d  = 1'b0;
        tap_chan_d   = tap_chan_q;
        tap_primed_d = tap_primed_q;
        for (int i = 0; i < NCH; i++) begin
            if (bus.flush[i]) begin
                hist_d[i][0] = '0;
                hist_d[i][1] = '0;
                hist_d[i][2] = '0;
                cnt_d[i]     = 2'd0;
            end else begin
                cnt_d[i] = cnt_d[i];
            end
        end
        if (gany_s) begin
            tap_valid_d          = 1'b1;
            tap_chan_d           = gidx_s;
            tap_a_d              = x_s;
            tap_b_d              = hist_d[gidx_s][0];
            tap_c_d              = hist_d[gidx_s][1];
            tap_d_d              = hist_d[gidx_s][2];
            tap_primed_d         = (cnt_d[gidx_s] == CNT_PRIMED);
            hist_d[gidx_s][2]    = hist_d[gidx_s][1];
            hist_d[gidx_s][1]    = hist_d[gidx_s][0];
            hist_d[gidx_s][0]    = x_s;
            cnt_d[gidx_s]        = cnt_inc(cnt_d[gidx_s]);
        end else begin
            tap_valid_d = 1'b0;
        end
    end

    // Tag pipe shadows the datapath so the tail lines up with sum_in.
    always_comb begin
        tag_d[0]             = '0;
        tag_d[0].valid       = tap_valid_q;
        tag_d[0].chan[CW-1:0] = tap_chan_q;
        tag_d[0].primed      = tap_primed_q;
        for (int k = 1; k < DEPTH; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    assign tail_s    = tag_q[DEPTH-1];
    // A tag naming a nonexistent channel is dropped rather than reported.
    assign tail_ok_s = tail_s.valid && ({1'b0, tail_s.chan} < (CHAN_W_MAX+1)'(NCH));

    // Result register; fields hold while no result is presented.
    always_comb begin
        out_valid_d  = tail_ok_s;
        out_chan_d   = out_chan_q;
        out_sum_d    = out_sum_q;
        out_primed_d = out_primed_q;
        if (tail_ok_s) begin
            out_chan_d   = tail_s.chan[CW-1:0];
            out_sum_d    = bus.sum_in;
            out_primed_d = tail_s.primed;
        end else begin
            out_sum_d    = out_sum_q;
        end
    end

    // State registers; reset discards history and every in-flight tag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NCH; i++) begin
                for (int j = 0; j < 3; j++) begin
                    hist_q[i][j] <= '0;
                end
                cnt_q[i] <= 2'd0;
            end
            tap_a_q      <= '0;
            tap_b_q      <= '0;
            tap_c_q      <= '0;
            tap_d_q      <= '0;
            tap_valid_q  <= 1'b0;
            tap_chan_q   <= '0;
            tap_primed_q <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                tag_q[k] <= '0;
            end
            out_valid_q  <= 1'b0;
            out_chan_q   <= '0;
            out_sum_q    <= '0;
            out_primed_q <= 1'b0;
        end else begin
            hist_q       <= hist_d;
            cnt_q        <= cnt_d;
            tap_a_q      <= tap_a_d;
            tap_b_q      <= tap_b_d;
            tap_c_q      <= tap_c_d;
            tap_d_q      <= tap_d_d;
            tap_valid_q  <= tap_valid_d;
            tap_chan_q   <= tap_chan_d;
            tap_primed_q <= tap_primed_d;
            tag_q        <= tag_d;
            out_valid_q  <= out_valid_d;
            out_chan_q   <= out_chan_d;
            out_sum_q    <= out_sum_d;
            out_primed_q <= out_primed_d;
        end
    end

    assign bus.tap_a      = tap_a_q;
    assign bus.tap_b      = tap_b_q;
    assign bus.tap_c      = tap_c_q;
    assign bus.tap_d      = tap_d_q;
    assign bus.tap_valid  = tap_valid_q;
    assign bus.tap_chan   = tap_chan_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_chan   = out_chan_q;
    assign bus.out_sum    = out_sum_q;
    assign bus.out_primed = out_primed_q;

endmodule
